// File: rtl/sample_scheduler.sv
// sample_scheduler: frame-based round-robin arbiter that grants one requester at a time,
// with completion, timeout and frame-overrun handling.
module sample_scheduler #(
    parameter int N       = 4,
    parameter int TIMEOUT = 200
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         ovr,
    output logic         tmo,
    output logic [7:0]   ovr_cnt
);
    localparam int W = $clog2(N);

    typedef enum logic [1:0] {IDLE, SCAN, BUSY} state_t;

    state_t       state;
    logic [N-1:0] pending, sel_hot, tick_req;
    logic [W-1:0] ptr, sel, cand;
    logic [7:0]   cnt;
    logic         found, overrun, finished;

    // Walk downward so the nearest index after ptr is the last one written.
    always_comb begin
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int i = N; i >= 1; i--) begin
            cand = W'((int'(ptr) + i) % N);
            if (pending[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign sel_hot  = N'(1) << sel;
    assign tick_req = tick ? req : '0;
    assign overrun  = tick && state != IDLE;
    assign finished = |(done & grant);
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            ptr     <= W'(N - 1);
            cnt     <= '0;
            grant   <= '0;
            ovr     <= 1'b0;
            tmo     <= 1'b0;
            ovr_cnt <= '0;
        end else begin
            ovr <= overrun;
            tmo <= 1'b0;
            if (overrun && ovr_cnt != 8'hff)
                ovr_cnt <= ovr_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        pending <= req;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (found) begin
                        grant   <= sel_hot;
                        pending <= (pending | tick_req) & ~sel_hot;
                        ptr     <= sel;
                        cnt     <= '0;
                        state   <= BUSY;
                    end else begin
                        // An empty scan with a coincident tick restarts the frame.
                        pending <= tick_req;
                        state   <= tick ? SCAN : IDLE;
                    end
                end
                BUSY: begin
                    cnt     <= cnt + 8'd1;
                    pending <= pending | tick_req;
                    if (finished || cnt == 8'(TIMEOUT - 1)) begin
                        grant <= '0;
                        tmo   <= !finished;
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
